// File: rtl/voxel_pixel_writeback.sv
// Generic FIFO plus the raycaster-to-framebuffer writeback with double buffering.
// Optional macro VOXEL_WB_STATS_EN adds the per-frame written-pixel counter output.

// Generic synchronous FIFO with occupancy count and show-ahead head entry.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the owner must not push when full or pop when empty.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Buffers 96-bit pixel writes and serialises each as three 32-bit framebuffer beats; flips front_buf per frame.
// Latency: pixel pushed at cycle N drives its first beat at N+2; 1 pixel per 3 cycles sustained.
// Backpressure: mem_wr_ready stalls the beat; the no-backpressure pixel port drops into drop_count/overflow.
module voxel_pixel_writeback #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          NUM_PIXELS = 172800,
    parameter logic [31:0] FB_BASE0   = 32'h0000_0000,
    parameter logic [31:0] FB_BASE1   = 32'h0020_0000,
    localparam int         LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pixel_write_en,
    input  logic [31:0]   pixel_addr,
    input  logic [31:0]   pixel_word0,
    input  logic [31:0]   pixel_word1,
    input  logic [31:0]   pixel_word2,
    input  logic          frame_done,
    output logic          mem_wr_valid,
    input  logic          mem_wr_ready,
    output logic [31:0]   mem_wr_addr,
    output logic [31:0]   mem_wr_data,
    output logic          front_buf,
    output logic          frame_swap,
    output logic          overflow,
    output logic [15:0]   drop_count,
    output logic [LW-1:0] fifo_level
`ifdef VOXEL_WB_STATS_EN
    ,
    output logic [23:0]   stat_frame_pixels
`endif
);
    typedef struct packed {
        logic        buf_tag;
        logic        last;
        logic        is_marker;
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
    } entry_t;

    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_PIX  = LW'(FIFO_DEPTH - 1);
    localparam logic [31:0]   PIX_LIM  = 32'(NUM_PIXELS);

    logic        back_buf;
    entry_t      push_ent;
    entry_t      head;
    entry_t      hold;
    logic        pix_in_range, pix_push, mk_need, mk_push, push, pop;
    logic        fifo_empty, b2_done, swap_evt;
    state_t      state, state_nxt;
    logic [31:0] beat_off;

    // The last slot is kept for markers so a frame end is not lost when pixels overflow.
    assign pix_in_range = pixel_write_en && (pixel_addr < PIX_LIM);
    assign pix_push     = pix_in_range && (fifo_level < LVL_PIX);
    assign mk_need      = frame_done && !pix_push;
    assign mk_push      = mk_need && (fifo_level != LVL_FULL);
    assign push         = pix_push || mk_push;
    assign push_ent     = '{buf_tag: back_buf, last: frame_done, is_marker: !pix_push,
                            addr: pixel_addr, w0: pixel_word0, w1: pixel_word1, w2: pixel_word2};

    wb_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head),
        .level    (fifo_level)
    );

    assign fifo_empty = (fifo_level == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            back_buf   <= 1'b1;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (frame_done) back_buf <= ~back_buf;
            if ((pix_in_range && !pix_push) || (mk_need && !mk_push)) overflow <= 1'b1;
            if (pixel_write_en && !pix_push && drop_count != 16'hFFFF)
                drop_count <= drop_count + 1'b1;
        end
    end

    assign b2_done = (state == B2) && mem_wr_ready;

    // A marker right behind a last-flagged pixel is popped a cycle later so each frame end gets its own pulse.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: pop = !fifo_empty;
            B0:   if (mem_wr_ready) state_nxt = B1;
            B1:   if (mem_wr_ready) state_nxt = B2;
            B2: begin
                if (mem_wr_ready) begin
                    state_nxt = IDLE;
                    pop = !fifo_empty && !(hold.last && head.is_marker);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (pop) state_nxt = head.is_marker ? IDLE : B0;
    end

    assign swap_evt = (pop && head.is_marker) || (b2_done && hold.last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            frame_swap <= 1'b0;
            front_buf  <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_swap <= swap_evt;
            if (pop)      hold      <= head;
            if (swap_evt) front_buf <= ~front_buf;
        end
    end

    always_comb begin
        mem_wr_data = hold.w0;
        beat_off    = 32'd0;
        case (state)
            B1: begin
                mem_wr_data = hold.w1;
                beat_off    = 32'd4;
            end
            B2: begin
                mem_wr_data = hold.w2;
                beat_off    = 32'd8;
            end
            default: ;
        endcase
    end

    assign mem_wr_valid = (state != IDLE);
    assign mem_wr_addr  = (hold.buf_tag ? FB_BASE1 : FB_BASE0)
                        + (hold.addr << 3) + (hold.addr << 2) + beat_off;

`ifdef VOXEL_WB_STATS_EN
    logic [23:0] pix_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt           <= '0;
            stat_frame_pixels <= '0;
        end else if (swap_evt) begin
            stat_frame_pixels <= pix_cnt + 24'(b2_done);
            pix_cnt           <= '0;
        end else if (b2_done) begin
            pix_cnt <= pix_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_voxel_pixel_writeback.sv
// Scoreboard bench for voxel_pixel_writeback: expected beats queued at stimulus, compared at handshake.
module tb_voxel_pixel_writeback;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_write_en = 1'b0;
    logic [31:0] pixel_addr = '0;
    logic [31:0] pixel_word0 = '0;
    logic [31:0] pixel_word1 = '0;
    logic [31:0] pixel_word2 = '0;
    logic        frame_done = 1'b0;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b1;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        front_buf;
    logic        frame_swap;
    logic        overflow;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;
`ifdef VOXEL_WB_STATS_EN
    logic [23:0] stat_frame_pixels;
`endif

    beat_t       exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          swap_cnt = 0;
    int          swap_base;
    int          mpix = 0;
    int          mstat = 0;
    int          mdrop = 0;
    logic        mbb = 1'b1;
    logic        mfront = 1'b0;
    logic [31:0] cap_a, cap_d;

    voxel_pixel_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_write_en (pixel_write_en),
        .pixel_addr     (pixel_addr),
        .pixel_word0    (pixel_word0),
        .pixel_word1    (pixel_word1),
        .pixel_word2    (pixel_word2),
        .frame_done     (frame_done),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_ready   (mem_wr_ready),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .front_buf      (front_buf),
        .frame_swap     (frame_swap),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .fifo_level     (fifo_level)
`ifdef VOXEL_WB_STATS_EN
        ,
        .stat_frame_pixels (stat_frame_pixels)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Beat monitor and swap monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && mem_wr_valid && mem_wr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {32'd0, mem_wr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_addr", {32'd0, mem_wr_addr}, {32'd0, e.a});
                chk("beat_data", {32'd0, mem_wr_data}, {32'd0, e.d});
            end
        end
        if (!rst && frame_swap) begin
            swap_cnt++;
            chk("swap_after_all_beats", exp_q.size(), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic en, input logic [31:0] a, input logic [31:0] w0,
                       input logic [31:0] w1, input logic [31:0] w2, input logic fd,
                       input logic acc);
        logic [31:0] base;
        base = mbb ? 32'h0020_0000 : 32'h0000_0000;
        pixel_write_en = en;
        pixel_addr     = a;
        pixel_word0    = w0;
        pixel_word1    = w1;
        pixel_word2    = w2;
        frame_done     = fd;
        if (acc) begin
            exp_q.push_back('{a: base + a * 12,      d: w0});
            exp_q.push_back('{a: base + a * 12 + 4,  d: w1});
            exp_q.push_back('{a: base + a * 12 + 8,  d: w2});
            mpix++;
        end else if (en) begin
            mdrop++;
        end
        if (fd) begin
            mbb    = ~mbb;
            mfront = ~mfront;
            mstat  = mpix;
            mpix   = 0;
        end
        tick();
        pixel_write_en = 1'b0;
        frame_done     = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_valid", mem_wr_valid, 0);
        chk("rst_front", front_buf, 0);
        chk("rst_swap", frame_swap, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;
        tick();

        // Single pixel, back buffer 1: first beat valid at N+2
        put(1'b1, 32'd5, 32'd11, 32'd22, 32'd33, 1'b0, 1'b1);
        chk("lat_n1_valid", mem_wr_valid, 0);
        tick();
        chk("lat_n2_valid", mem_wr_valid, 1);
        chk("first_addr", mem_wr_addr, 32'h0020_003C);
        chk("first_data", mem_wr_data, 32'd11);
        wait_drain();

        // Out-of-range pixel is dropped without overflow
        put(1'b1, 32'd172800, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
        repeat (5) tick();
        chk("oor_drop", drop_count, 1);
        chk("oor_ovf", overflow, 0);
        chk("oor_level", fifo_level, 0);

        // frame_done coincident with pixel addr 0: single last-flagged entry, then base 0
        swap_base = swap_cnt;
        put(1'b1, 32'd0, 32'hA0, 32'hA1, 32'hA2, 1'b1, 1'b1);
        wait_drain();
        chk("coinc_swaps", swap_cnt - swap_base, 1);
        chk("coinc_front", front_buf, mfront);
`ifdef VOXEL_WB_STATS_EN
        chk("coinc_stat", stat_frame_pixels, mstat);
`endif
        put(1'b1, 32'd7, 32'hB0, 32'hB1, 32'hB2, 1'b0, 1'b1);
        tick();
        chk("next_base0_addr", mem_wr_addr, 32'h0000_0054);
        wait_drain();

        // Three-pixel frame followed by a standalone frame_done marker
        swap_base = swap_cnt;
        for (int i = 0; i < 3; i++)
            put(1'b1, 32'(i + 1), 32'(16 * i + 1), 32'(16 * i + 2), 32'(16 * i + 3), 1'b0, 1'b1);
        put(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        wait_drain();
        chk("frame_swaps", swap_cnt - swap_base, 1);
        chk("frame_front", front_buf, mfront);
`ifdef VOXEL_WB_STATS_EN
        chk("frame_stat", stat_frame_pixels, mstat);
`endif

        // Stall: one pixel parked in the holding register, then 20 more with ready low
        mem_wr_ready = 1'b0;
        put(1'b1, 32'd200, 32'hC0, 32'hC1, 32'hC2, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            put(1'b1, 32'(300 + i), 32'(1000 + i), 32'(2000 + i), 32'(3000 + i), 1'b0, i < 15);
        cap_a = mem_wr_addr;
        cap_d = mem_wr_data;
        chk("stall_level", fifo_level, 15);
        chk("stall_ovf", overflow, 1);
        chk("stall_drop", drop_count, mdrop);
        repeat (19) tick();
        chk("stall_valid", mem_wr_valid, 1);
        chk("stall_addr_stable", mem_wr_addr, cap_a);
        chk("stall_data_stable", mem_wr_data, cap_d);
        chk("stall_addr_exp", mem_wr_addr, exp_q[0].a);
        mem_wr_ready = 1'b1;
        wait_drain();
        chk("stall_level_after", fifo_level, 0);

        // Reset asserted while the pixel is in its second beat
        put(1'b1, 32'd3, 32'hD0, 32'hD1, 32'hD2, 1'b0, 1'b1);
        tick();
        tick();
        chk("b1_valid", mem_wr_valid, 1);
        chk("b1_data", mem_wr_data, 32'hD1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", mem_wr_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_front", front_buf, 0);
        exp_q.delete();
        mbb = 1'b1;
        mfront = 1'b0;
        mpix = 0;
        mdrop = 0;
        tick();
        rst = 1'b0;
        tick();
        put(1'b1, 32'd9, 32'hE0, 32'hE1, 32'hE2, 1'b0, 1'b1);
        tick();
        chk("postrst_addr", mem_wr_addr, 32'h0020_006C);
        wait_drain();
        chk("postrst_drop", drop_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/voxel_pixel_writeback.md
Name: voxel_pixel_writeback

Overview:
- Sits directly downstream of the raycaster pixel port (pixel_write_en / pixel_addr / pixel_word0..2 / frame_done).
- Buffers each 96-bit pixel write in a FIFO and serialises it as three 32-bit beats onto a ready/valid framebuffer memory write bus.
- Manages double buffering: the raycaster always renders into the back buffer. The front buffer flips only after every beat of the finished frame has been accepted.
- The raycaster port has no backpressure, so the FIFO absorbs stalls and counts drops.

Parameters:
- FIFO_DEPTH, 16, entry count; power of two, minimum 4.
- NUM_PIXELS, 172800, valid pixel_addr range is 0..NUM_PIXELS-1 (480x360).
- FB_BASE0, 32'h0000_0000, byte base address of buffer 0.
- FB_BASE1, 32'h0020_0000, byte base address of buffer 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- pixel_write_en  in  1  pixel write strobe, one pixel per cycle.
- pixel_addr  in  32  pixel index.
- pixel_word0  in  32  pixel payload word 0.
- pixel_word1  in  32  pixel payload word 1.
- pixel_word2  in  32  pixel payload word 2.
- frame_done  in  1  end-of-frame pulse.
- mem_wr_valid  out  1  beat valid.
- mem_wr_ready  in  1  beat accepted when valid&&ready.
- mem_wr_addr  out  32  beat byte address.
- mem_wr_data  out  32  beat data.
- front_buf  out  1  buffer currently displayed.
- frame_swap  out  1  one-cycle pulse when front_buf toggles.
- overflow  out  1  sticky; set on any dropped pixel or marker.
- drop_count  out  16  dropped pixels, saturating at 16'hFFFF.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - all outputs 0 except front_buf=0; internal back_buf=1; FIFO empty; drain FSM in IDLE.
  - Reset mid-burst discards the entry in flight with no partial completion.
- Entry format: {buf_tag, last, is_marker, addr[31:0], w0, w1, w2}.
- Enqueue, per cycle:
  - pixel_write_en with pixel_addr < NUM_PIXELS: push a pixel entry with buf_tag=back_buf.
  - pixel_write_en with pixel_addr >= NUM_PIXELS: drop the pixel, increment drop_count, do not set overflow.
  - frame_done together with an accepted pixel push: that entry gets last=1.
  - frame_done alone: push a marker entry (is_marker=1, last=1).
  - frame_done always toggles back_buf at the clock edge; entries pushed in the same cycle carry the old tag.
- Full handling:
  - Pixel entries are refused when level >= FIFO_DEPTH-1. The final slot is reserved for markers.
  - Refused pixel: overflow=1, drop_count+1. If frame_done coincides with a refused pixel, push a marker instead.
  - Marker refused at level == FIFO_DEPTH: overflow=1, and that frame never swaps.
- Drain FSM, states IDLE, B0, B1, B2:
  - IDLE with FIFO non-empty: pop the head into a holding register.
    - Marker: no beats. Pulse frame_swap and toggle front_buf on the next cycle. Stay in IDLE.
    - Pixel: go to B0.
  - Bk (k = 0, 1, 2) drives:
    - mem_wr_valid=1;
    - mem_wr_data = w_k;
    - mem_wr_addr = base(buf_tag) + addr*12 + 4k, arithmetic mod 2^32, where base = FB_BASE0 if tag 0, else FB_BASE1.
  - Valid, addr and data are held stable until ready.
  - Handshake in B0 goes to B1; in B1 goes to B2.
  - Handshake in B2 with last=1: frame_swap pulses and front_buf toggles in the following cycle.
  - Handshake in B2 then goes to IDLE. A back-to-back pop is allowed in that same cycle, so a pixel in B2 followed by a queued pixel reaches B0 with no bubble.
- Latency and throughput:
  - Pixel pushed at cycle N gives its first beat valid at N+2 (push, pop).
  - Sustained throughput is 1 pixel per 3 cycles.
- Simultaneous push and pop: fifo_level is unchanged.
- fifo_level counts entries not yet popped into the holding register.

Optional Feature:
- VOXEL_WB_STATS_EN adds output stat_frame_pixels (24 bits).
  - Counts pixel entries fully written for the current frame.
  - The count is latched to the output on each frame_swap; the counter then restarts at 0.
  - A last-flagged pixel is included in the frame it ends.
- Without the macro the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Single pixel at addr 5, words 11/22/33, back_buf=1, mem_wr_ready=1 -> beats at 0x0020003C, 0x00200040, 0x00200044 carrying 11, 22, 33; first valid at cycle N+2.
- 3-pixel frame then frame_done alone, mem_wr_ready=1 -> 9 beats, then frame_swap one cycle; front_buf 0->1; stat_frame_pixels=3 when VOXEL_WB_STATS_EN is defined.
- mem_wr_ready=0 for 40 cycles while 20 pixels arrive (FIFO_DEPTH=16) -> 15 enqueued (level 15), overflow=1, drop_count=5; addr and data stable through the stall.
- frame_done coincident with pixel addr 0 -> that entry has last=1, no marker pushed; swap pulses after its B2 handshake; the next pixel uses the FB_BASE0 base.
- pixel_addr=172800 -> no beats, drop_count=1, overflow stays 0.
- Assert rst during B1 -> mem_wr_valid=0 immediately, FIFO empty, front_buf=0; a new pixel after release is written to FB_BASE1.
